tape_head: RTL and testbench
============================

TAPE_HEAD -- requirements
Module: tape_head

Interface
REQ-001 Parameter TAPE_LEN, default 16, number of tape cells; power of two, at least 4.
REQ-002 Parameter HEAD_INIT, default 8, head cell index after reset.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named as the codebase does:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
REQ-004 Remaining ports SHALL be:
- step_valid  in  1  step request
- step_ready  out  1  block can accept a step
- write_sym  in  3  symbol {s2,s1,s0} to write at current head cell
- direction  in  1  head move after write: 1 = right (+1), 0 = left (-1); same encoding the direction logic produces
- read_valid  out  1  one-cycle pulse, read_sym valid
- read_sym  out  3  symbol under head after move
- head_pos  out  log2(TAPE_LEN)  current head index
- fault  out  1  sticky tape-edge overrun flag

Function
REQ-005 A step SHALL be accepted on a rising edge where step_valid && step_ready; write_sym and direction SHALL be sampled only at that edge.
REQ-006 step_ready SHALL equal (state == IDLE) && !fault; step_valid while not ready SHALL be ignored with no side effect.
REQ-007 FSM states SHALL be IDLE, MOVE, READ, FAULT.
REQ-008 IDLE: on acceptance, cell[head_pos] <= write_sym and direction registered; next state MOVE.
REQ-009 MOVE, legal move: head_pos +1 (right) or -1 (left); next state READ.
REQ-010 MOVE, illegal move (left at index 0, or right at TAPE_LEN-1): head_pos unchanged, fault <= 1, next state FAULT; no wrap-around.
REQ-011 READ: read_sym <= cell[head_pos] (new position), read_valid <= 1 for exactly one cycle; next state IDLE.
REQ-012 Latency: acceptance at edge E0 -> read_valid high in the cycle after edge E2; one step per 3 cycles maximum.
REQ-013 read_sym SHALL hold its value between read_valid pulses.
REQ-014 FAULT is terminal: step_ready low, read_valid low, tape and head frozen until reset.
REQ-015 The write at E0 SHALL complete even if the subsequent move faults.
REQ-016 A step that moves onto a just-written cell (impossible within one step) needs no forwarding; cell reads in READ SHALL see all prior writes.

Reset
REQ-017 With rst_n low at a rising edge: state IDLE, all cells = blank 3'b000, head_pos = HEAD_INIT, read_sym = 3'b000, read_valid = 0, fault = 0.
REQ-018 Reset SHALL override any in-flight step (MOVE/READ); the aborted step SHALL produce no read_valid pulse.
REQ-019 step_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-020 Shared package tm_pkg SHALL hold SYM_BLANK (3'b000), DIR_LEFT (0), DIR_RIGHT (1) and the tape_head state encoding.
REQ-021 Tape storage SHALL be a sub-module tape_mem: TAPE_LEN x 3-bit register array, synchronous write, combinational read, synchronous reset to SYM_BLANK.
REQ-022 All outputs SHALL be registered or decoded from state only; no combinational path from step_valid to any output.

Verification
REQ-023 Reset, then step(write 3'b101, right) -> read_valid 3 cycles after accept, read_sym 3'b000, head_pos 9, cell 8 = 3'b101.
REQ-024 From head 9 step(write 3'b010, left) -> head_pos 8, read_sym 3'b101; then step(3'b111, right) -> read_sym 3'b010.
REQ-025 Drive head to 0, step(write 3'b001, left) -> fault 1, head_pos 0, no read_valid, step_ready stays 0; cell 0 = 3'b001.
REQ-026 Drive head to 15, step(right) -> fault 1, head_pos 15; hold step_valid 10 cycles -> no acceptance.
REQ-027 Assert rst_n low during READ -> no read_valid pulse, head_pos 8, all cells 3'b000, step_ready 1 next cycle.
REQ-028 step_valid held high continuously for 6 steps right from reset -> exactly 6 read_valid pulses spaced 3 cycles, head_pos 14.

Source files
------------

// File: rtl/tm_pkg.sv
// Shared constants for the tape machine: symbol encoding, head directions
// and the tape_head controller state encoding.
package tm_pkg;

  typedef logic [2:0] sym_t;

  localparam sym_t SYM_BLANK = 3'b000;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

endpackage

// File: rtl/tape_mem.sv
// Tape cell storage: one synchronous write port, one combinational read port,
// every cell cleared to blank on reset.
module tape_mem
  import tm_pkg::*;
#(
  parameter int TAPE_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [$clog2(TAPE_LEN)-1:0] waddr,
  input  sym_t                        wdata,
  input  logic [$clog2(TAPE_LEN)-1:0] raddr,
  output sym_t                        rdata
);

  sym_t cells [TAPE_LEN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPE_LEN; i++) cells[i] <= SYM_BLANK;
    end else if (we) begin
      cells[waddr] <= wdata;
    end
  end

  assign rdata = cells[raddr];

endmodule

// File: rtl/tape_head.sv
// Turing-style tape head: write the current cell, move one cell, read the new
// cell back. Running off either end of the tape latches a terminal fault.
//
// state | meaning
// IDLE  | waiting for a step; write happens on acceptance
// MOVE  | shift head by one cell, or fault at a tape edge
// READ  | capture the cell under the new head, pulse read_valid
// FAULT | terminal until reset; tape and head frozen
module tape_head
  import tm_pkg::*;
#(
  parameter int TAPE_LEN  = 16,
  parameter int HEAD_INIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        step_valid,
  output logic                        step_ready,
  input  logic [2:0]                  write_sym,
  input  logic                        direction,
  output logic                        read_valid,
  output logic [2:0]                  read_sym,
  output logic [$clog2(TAPE_LEN)-1:0] head_pos,
  output logic                        fault
);

  localparam int AW = $clog2(TAPE_LEN);
  localparam logic [AW-1:0] POS_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] POS_LAST = AW'(TAPE_LEN - 1);
  localparam logic [AW-1:0] POS_INIT = AW'(HEAD_INIT);

  logic [1:0] state;
  logic       dir_q;
  logic       accept;
  logic       edge_hit;
  sym_t       cell_rd;

  assign step_ready = (state == ST_IDLE) && !fault;
  assign accept     = step_valid && step_ready;
  assign edge_hit   = (dir_q == DIR_LEFT)  ? (head_pos == '0)
                                           : (head_pos == POS_LAST);

  tape_mem #(.TAPE_LEN(TAPE_LEN)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (head_pos),
    .wdata (write_sym),
    .raddr (head_pos),
    .rdata (cell_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      head_pos   <= POS_INIT;
      dir_q      <= DIR_LEFT;
      read_sym   <= SYM_BLANK;
      read_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      read_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir_q <= direction;
            state <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          // No wrap-around: an edge overrun leaves the head where it is.
          if (edge_hit) begin
            fault <= 1'b1;
            state <= ST_FAULT;
          end else begin
            head_pos <= (dir_q == DIR_RIGHT) ? head_pos + POS_ONE
                                             : head_pos - POS_ONE;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          read_sym   <= cell_rd;
          read_valid <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tape_head.sv
// Directed bench for tape_head: a vector table of write/move/read steps plus
// hand-written sequences for edge faults, aborted steps and back-to-back steps.
module tb_tape_head;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_valid;
  logic       step_ready;
  logic [2:0] write_sym;
  logic       direction;
  logic       read_valid;
  logic [2:0] read_sym;
  logic [3:0] head_pos;
  logic       fault;

  int errors = 0;
  int checks = 0;

  tape_head #(.TAPE_LEN(16), .HEAD_INIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .write_sym  (write_sym),
    .direction  (direction),
    .read_valid (read_valid),
    .read_sym   (read_sym),
    .head_pos   (head_pos),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] wsym;
    logic       dir;
    logic [3:0] exp_head;
    logic [2:0] exp_rsym;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step_valid = 1'b0;
    write_sym = 3'b000;
    direction = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Returns cycles from the accepting edge to read_valid, or -1 if none in 6.
  task automatic do_step(input logic [2:0] w, input logic d, output int lat);
    write_sym = w;
    direction = d;
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (read_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  int lat;
  int nz;
  int pulses;
  int accepts;
  int last_pulse;
  int gap_bad;

  initial begin
    vecs[0] = '{3'b101, 1'b1, 4'd9,  3'b000};
    vecs[1] = '{3'b010, 1'b0, 4'd8,  3'b101};
    vecs[2] = '{3'b111, 1'b1, 4'd9,  3'b010};
    vecs[3] = '{3'b011, 1'b1, 4'd10, 3'b000};
    vecs[4] = '{3'b110, 1'b0, 4'd9,  3'b011};
    vecs[5] = '{3'b100, 1'b0, 4'd8,  3'b111};

    do_reset();
    chk("reset_ready", int'(step_ready), 1);
    chk("reset_head", int'(head_pos), 8);
    chk("reset_rv", int'(read_valid), 0);
    chk("reset_rsym", int'(read_sym), 0);
    chk("reset_fault", int'(fault), 0);

    for (int i = 0; i < 6; i++) begin
      do_step(vecs[i].wsym, vecs[i].dir, lat);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_rsym", i), int'(read_sym), int'(vecs[i].exp_rsym));
      chk($sformatf("vec%0d_head", i), int'(head_pos), int'(vecs[i].exp_head));
      if (i == 0) chk("vec0_cell8", int'(dut.u_mem.cells[8]), 5);
      tick();
      chk($sformatf("vec%0d_rv_drop", i), int'(read_valid), 0);
      chk($sformatf("vec%0d_rsym_hold", i), int'(read_sym), int'(vecs[i].exp_rsym));
    end

    // Left edge overrun
    do_reset();
    for (int i = 0; i < 8; i++) do_step(3'b000, 1'b0, lat);
    chk("left_head_at_0", int'(head_pos), 0);
    do_step(3'b001, 1'b0, lat);
    chk("left_fault_no_rv", lat, -1);
    chk("left_fault_flag", int'(fault), 1);
    chk("left_fault_head", int'(head_pos), 0);
    chk("left_fault_ready", int'(step_ready), 0);
    chk("left_fault_cell0", int'(dut.u_mem.cells[0]), 1);

    // Right edge overrun, then a held request must not be accepted
    do_reset();
    for (int i = 0; i < 7; i++) do_step(3'b000, 1'b1, lat);
    chk("right_head_at_15", int'(head_pos), 15);
    do_step(3'b110, 1'b1, lat);
    chk("right_fault_no_rv", lat, -1);
    chk("right_fault_flag", int'(fault), 1);
    chk("right_fault_head", int'(head_pos), 15);
    write_sym = 3'b011;
    direction = 1'b0;
    step_valid = 1'b1;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (read_valid || step_ready) pulses++;
    end
    step_valid = 1'b0;
    chk("right_hold_no_accept", pulses, 0);
    chk("right_hold_head", int'(head_pos), 15);
    chk("right_hold_cell15", int'(dut.u_mem.cells[15]), 6);

    // Reset arriving while the step sits in READ
    do_reset();
    do_step(3'b101, 1'b1, lat);
    write_sym = 3'b010;
    direction = 1'b0;
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_rv", int'(read_valid), 0);
    chk("abort_head", int'(head_pos), 8);
    nz = 0;
    for (int i = 0; i < 16; i++) if (dut.u_mem.cells[i] != 3'b000) nz++;
    chk("abort_cells_blank", nz, 0);
    rst_n = 1'b1;
    chk("abort_ready_after", int'(step_ready), 1);
    tick();
    chk("abort_rv_later", int'(read_valid), 0);

    // step_valid held for six back-to-back right steps
    do_reset();
    direction = 1'b1;
    write_sym = 3'b001;
    step_valid = 1'b1;
    accepts = 0;
    pulses = 0;
    last_pulse = -1;
    gap_bad = 0;
    for (int n = 0; n < 40; n++) begin
      if (step_valid && step_ready) accepts++;
      tick();
      if (accepts == 6) step_valid = 1'b0;
      if (read_valid) begin
        if (last_pulse >= 0 && (n - last_pulse) != 3) gap_bad++;
        last_pulse = n;
        pulses++;
      end
    end
    step_valid = 1'b0;
    chk("burst_pulses", pulses, 6);
    chk("burst_spacing_bad", gap_bad, 0);
    chk("burst_head", int'(head_pos), 14);
    chk("burst_fault", int'(fault), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
